// File: rtl/pc_ctrl_pkg.sv
// Shared encodings and constants for the PC sequencer and its next-PC mux.
package pc_ctrl_pkg;

  localparam int          XLEN_DEF   = 32;
  localparam int          INST_BYTES = 4;
  localparam logic [31:0] RESET_PC   = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH_REQ  = 3'd1,
    S_FETCH_WAIT = 3'd2,
    S_EXEC       = 3'd3,
    S_HALT       = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    NPC_SEQ  = 2'd0,
    NPC_BR   = 2'd1,
    NPC_TRAP = 2'd2,
    NPC_RET  = 2'd3
  } npc_sel_t;

endpackage

// File: rtl/pc_ctrl_npc_sel.sv
// Next-PC priority mux: turns a fetch error or a completed instruction into
// PC-adder operands and a write enable; ebreak requests a halt instead.
module npc_sel
  import pc_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            trap_fetch_i,
  input  logic            done_i,
  input  logic            ebreak_i,
  input  logic            ecall_i,
  input  logic            mret_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [XLEN-1:0] br_base_i,
  input  logic [XLEN-1:0] br_off_i,
  output logic [XLEN-1:0] a_o,
  output logic [XLEN-1:0] b_o,
  output logic            wen_o,
  output logic            halt_o
);

  npc_sel_t sel;

  always_comb begin
    sel    = NPC_SEQ;
    wen_o  = 1'b0;
    halt_o = 1'b0;
    if (trap_fetch_i) begin
      sel   = NPC_TRAP;
      wen_o = 1'b1;
    end else if (done_i) begin
      if (ebreak_i) begin
        halt_o = 1'b1;
      end else begin
        wen_o = 1'b1;
        if (ecall_i)         sel = NPC_TRAP;
        else if (mret_i)     sel = NPC_RET;
        else if (br_taken_i) sel = NPC_BR;
        else                 sel = NPC_SEQ;
      end
    end
  end

  // Outside a write cycle the operands rest at pc/4 so they never float.
  always_comb begin
    a_o = pc_i;
    b_o = XLEN'(INST_BYTES);
    if (wen_o) begin
      case (sel)
        NPC_TRAP: begin a_o = mtvec_i;   b_o = '0;       end
        NPC_RET:  begin a_o = mepc_i;    b_o = '0;       end
        NPC_BR:   begin a_o = br_base_i; b_o = br_off_i; end
        default:  begin a_o = pc_i;      b_o = XLEN'(INST_BYTES); end
      endcase
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Multi-cycle fetch/execute sequencer driving the PC adder, the fetch
// handshake, trap/return redirects, halt/timeout detection and perf counters.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_a,
  output logic [XLEN-1:0]  pc_b,
  output logic             pc_wen,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  output logic [XLEN-1:0]  ifu_req_addr,
  input  logic             ifu_rsp_valid,
  output logic             ifu_rsp_ready,
  input  logic [31:0]      ifu_rsp_inst,
  input  logic             ifu_rsp_err,
  output logic [31:0]      inst,
  output logic             inst_valid,
  input  logic             exu_done,
  input  logic             br_taken,
  input  logic [XLEN-1:0]  br_base,
  input  logic [XLEN-1:0]  br_off,
  input  logic             ecall,
  input  logic             mret,
  input  logic             ebreak,
  input  logic [XLEN-1:0]  mtvec,
  input  logic [XLEN-1:0]  mepc,
  output logic             halted,
  output logic             timeout,
  output logic             fetch_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT) + 1;

  state_t            state_q;
  logic [WAIT_W-1:0] wait_q;
  logic [31:0]       inst_q;
  logic              inst_vld_q;
  logic              timeout_q;
  logic [CNT_W-1:0]  cycle_q;
  logic [CNT_W-1:0]  instret_q;

  logic            ferr_d;
  logic            done_d;
  logic [XLEN-1:0] sel_a;
  logic [XLEN-1:0] sel_b;
  logic            sel_wen;
  logic            halt_req;

  // Handshakes are gated by rst so nothing is accepted in the reset cycle itself.
  assign ferr_d = rst && (state_q == S_FETCH_WAIT) && ifu_rsp_valid && ifu_rsp_err;
  assign done_d = rst && (state_q == S_EXEC) && exu_done;

  npc_sel #(.XLEN(XLEN)) u_npc_sel (
    .trap_fetch_i (ferr_d),
    .done_i       (done_d),
    .ebreak_i     (ebreak),
    .ecall_i      (ecall),
    .mret_i       (mret),
    .br_taken_i   (br_taken),
    .pc_i         (pc),
    .mtvec_i      (mtvec),
    .mepc_i       (mepc),
    .br_base_i    (br_base),
    .br_off_i     (br_off),
    .a_o          (sel_a),
    .b_o          (sel_b),
    .wen_o        (sel_wen),
    .halt_o       (halt_req)
  );

  assign pc_wen        = sel_wen;
  assign pc_a          = (rst && state_q != S_IDLE) ? sel_a : '0;
  assign pc_b          = (rst && state_q != S_IDLE) ? sel_b : '0;
  assign ifu_req_valid = rst && (state_q == S_FETCH_REQ);
  assign ifu_req_addr  = ifu_req_valid ? pc : '0;
  assign ifu_rsp_ready = rst && (state_q == S_FETCH_WAIT);
  assign fetch_err     = ferr_d;
  assign inst          = inst_q;
  assign inst_valid    = inst_vld_q;
  assign halted        = (state_q == S_HALT);
  assign timeout       = timeout_q;
  assign cycle_cnt     = cycle_q;
  assign instret_cnt   = instret_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      inst_q     <= '0;
      inst_vld_q <= 1'b0;
      timeout_q  <= 1'b0;
      cycle_q    <= '0;
      instret_q  <= '0;
    end else begin
      inst_vld_q <= 1'b0;
      if (state_q != S_HALT) cycle_q <= cycle_q + CNT_W'(1);
      case (state_q)
        S_IDLE: state_q <= S_FETCH_REQ;
        S_FETCH_REQ: begin
          if (ifu_req_ready) begin
            state_q <= S_FETCH_WAIT;
            wait_q  <= '0;
          end
        end
        S_FETCH_WAIT: begin
          wait_q <= wait_q + WAIT_W'(1);
          // A response in the last allowed cycle still beats the timeout.
          if (ifu_rsp_valid) begin
            if (ifu_rsp_err) begin
              state_q <= S_FETCH_REQ;
            end else begin
              inst_q     <= ifu_rsp_inst;
              inst_vld_q <= 1'b1;
              state_q    <= S_EXEC;
            end
          end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= S_HALT;
          end
        end
        S_EXEC: begin
          if (exu_done) begin
            instret_q <= instret_q + CNT_W'(1);
            state_q   <= halt_req ? S_HALT : S_FETCH_REQ;
          end
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Multi-cycle sequencer for the PC register/adder block (dnpc = a + b, registered on wen; resets to 0x8000_0000).
- Drives the PC adder operands and write enable.
- Runs the instruction-fetch valid/ready handshake and holds the fetched instruction for decode/execute.
- Selects next-PC source (sequential, branch/jump, trap, mret), detects halt and fetch timeout, and keeps cycle/instret counters.

Parameters:
- XLEN, 32, datapath/address width.
- TIMEOUT, 1024, max cycles in FETCH_WAIT before timeout halt.
- CNT_W, 64, width of perf counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset, sampled on posedge clk.
- pc  in  XLEN  current PC (dnpc of PC block).
- pc_a  out  XLEN  PC adder operand a.
- pc_b  out  XLEN  PC adder operand b.
- pc_wen  out  1  PC register write enable.
- ifu_req_valid  out  1  fetch request valid.
- ifu_req_ready  in  1  fetch request accepted.
- ifu_req_addr  out  XLEN  fetch address.
- ifu_rsp_valid  in  1  fetch response valid.
- ifu_rsp_ready  out  1  controller accepts response.
- ifu_rsp_inst  in  32  fetched instruction.
- ifu_rsp_err  in  1  fetch bus error, qualified by rsp_valid.
- inst  out  32  latched instruction.
- inst_valid  out  1  one-cycle pulse: new inst for decode.
- exu_done  in  1  execute/writeback complete for current inst.
- br_taken  in  1  redirect requested; qualified by exu_done.
- br_base  in  XLEN  redirect base (pc or rs1).
- br_off  in  XLEN  redirect offset (imm).
- ecall, mret, ebreak  in  1 each  qualified by exu_done.
- mtvec, mepc  in  XLEN  trap vector / return address.
- halted  out  1  core stopped.
- timeout  out  1  sticky: halt caused by fetch timeout.
- fetch_err  out  1  one-cycle pulse on errored response.
- cycle_cnt, instret_cnt  out  CNT_W  perf counters.

Behaviour:
- States: IDLE, FETCH_REQ, FETCH_WAIT, EXEC, HALT.
- Reset (rst==0 at posedge): state=IDLE; all outputs 0, including inst, counters and timeout; wait counter cleared. Applies from any state and abandons in-flight fetches. rsp_ready stays 0 until FETCH_WAIT, so stale responses stall in the interconnect.
- IDLE: unconditionally -> FETCH_REQ next cycle.
- FETCH_REQ:
  - ifu_req_valid=1, ifu_req_addr=pc. Address is held stable while valid and ready is low.
  - On valid&ready -> FETCH_WAIT; wait counter cleared.
- FETCH_WAIT:
  - ifu_rsp_ready=1; wait counter increments each cycle.
  - rsp_valid & !rsp_err: inst<=ifu_rsp_inst; inst_valid=1 the following cycle (first EXEC cycle only); -> EXEC.
  - rsp_valid & rsp_err: fetch_err=1 this cycle; pc_wen=1, a=mtvec, b=0; -> FETCH_REQ. instret not incremented.
  - Wait counter reaching TIMEOUT-1 without rsp_valid: timeout<=1 -> HALT. rsp_valid wins if it arrives in the same cycle.
- EXEC: waits for exu_done, then resolves the redirect in the same cycle (pc_wen combinational with exu_done). Priority, highest first:
  - ebreak: pc_wen=0, -> HALT.
  - ecall: a=mtvec, b=0.
  - mret: a=mepc, b=0.
  - br_taken: a=br_base, b=br_off.
  - else: a=pc, b=4.
  - For all non-ebreak cases: pc_wen=1, -> FETCH_REQ, instret_cnt+=1 (also for ebreak).
  - The new PC is visible on pc in FETCH_REQ; fetch latency is therefore at least 1 cycle after the update.
- HALT: halted=1; all handshakes, pc_wen and inst_valid deasserted; exits only via reset.
- pc_a/pc_b outside a pc_wen cycle: hold pc/4 (don't-care to PC, fixed for determinism).
- cycle_cnt increments every cycle except reset and HALT; both counters wrap modulo 2^CNT_W.
- inst holds its value until the next successful fetch.
- Adder arithmetic (unsigned add, mod 2^XLEN) lives in the PC block. The controller performs no alignment check; bit0 masking for jalr is the caller's job in br_base/br_off.

Decomposition:
- Shared package: state enum encoding (IDLE=0, FETCH_REQ=1, FETCH_WAIT=2, EXEC=3, HALT=4), XLEN, INST_BYTES=4, RESET_PC=0x8000_0000, next-PC select enum (SEQ, BR, TRAP, RET).
- One natural sub-module: npc_sel, the combinational priority mux producing pc_a/pc_b/sel from exu_done/ebreak/ecall/mret/br_taken.
- Counters and FSM stay in pc_ctrl.

Test Plan:
- Reset then straight-line: req_ready/rsp_valid=1 immediately, exu_done 1 cycle after inst_valid. Required: addrs 0x80000000, 0x80000004, 0x80000008; pc_b=4 each update; instret_cnt=3 after third exu_done.
- Branch: pc=0x80000010, br_taken=1, br_base=0x80000010, br_off=0xFFFFFFF0 -> pc_a/pc_b equal those values with pc_wen=1; next ifu_req_addr=0x80000000.
- Priority: ecall=1, br_taken=1, mret=1, mtvec=0x80001000 in one exu_done cycle -> a=0x80001000, b=0. Then mret alone with mepc=0x80000044 -> next fetch addr 0x80000044.
- Backpressure/error: req_ready low 5 cycles -> ifu_req_addr stable, no state change. Then rsp_valid with rsp_err=1 -> fetch_err pulse, pc_wen with a=mtvec, no inst_valid, instret unchanged.
- Timeout/halt: TIMEOUT=8, rsp_valid never asserted -> halted=1 and timeout=1 exactly 8 cycles after request accept. Separately, ebreak on exu_done -> halted=1, pc_wen=0, cycle_cnt frozen.
- Reset mid-fetch: rst=0 during FETCH_WAIT -> next cycle all outputs 0, state IDLE. After release, fresh request at current pc; response arriving during reset not consumed (rsp_ready=0).
